// File: rtl/gate_pkg.sv
// Shared types and default timing constants for the parking barrier sequencer.
package gate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_OPENING   = 2'b01,
        ST_OPEN_HOLD = 2'b10,
        ST_CLOSING   = 2'b11
    } gate_state_e;

    typedef enum logic {
        LANE_ENTRY = 1'b0,
        LANE_EXIT  = 1'b1
    } lane_e;

    localparam int unsigned DEF_PERIOD_CYCLES = 1_500_000;
    localparam int unsigned DEF_OPEN_PULSE    = 80_000;
    localparam int unsigned DEF_CLOSE_PULSE   = 26_000;
    localparam int unsigned DEF_TRAVEL_CYCLES = 25_000_000;
    localparam int unsigned DEF_HOLD_CYCLES   = 100_000_000;
    localparam int unsigned DEF_WDOG_CYCLES   = 1_500_000_000;

    // Counter width for a count range of n values; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: free-running period counter, pulse width reloaded only at wrap.
module servo_pwm_gen
    import gate_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int unsigned OPEN_PULSE    = DEF_OPEN_PULSE,
    parameter int unsigned CLOSE_PULSE   = DEF_CLOSE_PULSE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic target_open,
    output logic pwm
);

    localparam int unsigned CW = cnt_w(PERIOD_CYCLES);

    logic [CW-1:0] cnt;
    logic [CW-1:0] width;

    // Width changes only at the period boundary so no pulse is ever cut or stretched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            width <= CW'(CLOSE_PULSE);
            pwm   <= 1'b0;
        end else begin
            pwm <= (cnt < width);
            if (cnt == CW'(PERIOD_CYCLES - 1)) begin
                cnt   <= '0;
                width <= target_open ? CW'(OPEN_PULSE) : CW'(CLOSE_PULSE);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/gate_sequencer.sv
// Barrier sequencer: lane arbitration, occupancy gating, open/hold/close FSM with reversal.
// Optional beam-blocked watchdog enabled by defining GATE_WATCHDOG_EN.
module gate_sequencer
    import gate_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int unsigned OPEN_PULSE    = DEF_OPEN_PULSE,
    parameter int unsigned CLOSE_PULSE   = DEF_CLOSE_PULSE,
    parameter int unsigned TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES
`ifdef GATE_WATCHDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES   = DEF_WDOG_CYCLES
`endif
) (
    input  logic       clock_50MHz,
    input  logic       reset_n,
    input  logic       entry_ir_n,
    input  logic       exit_ir_n,
    input  logic [5:0] position_free,
    output logic       servo_pwm,
    output logic       grant_entry,
    output logic       grant_exit,
    output logic       gate_open,
    output logic       lot_full,
    output logic       gate_fault,
    output logic [1:0] state_dbg
);

    localparam int unsigned TRAVEL_W = cnt_w(TRAVEL_CYCLES);
    localparam int unsigned HOLD_W   = cnt_w(HOLD_CYCLES);

    gate_state_e         state, state_next;
    logic [TRAVEL_W-1:0] travel_cnt, travel_next;
    logic [HOLD_W-1:0]   hold_cnt, hold_next;
    logic                grant_entry_next, grant_exit_next, gate_open_next;
    lane_e               last_served, last_next;
    logic [1:0]          entry_sync, exit_sync;
    logic                entry_blk, exit_blk, own_blk, req_entry, req_exit;

    // Beams reset to "clear" so reset release never looks like a car.
    always_ff @(posedge clock_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            entry_sync <= 2'b11;
            exit_sync  <= 2'b11;
            lot_full   <= 1'b0;
        end else begin
            entry_sync <= {entry_sync[0], entry_ir_n};
            exit_sync  <= {exit_sync[0], exit_ir_n};
            lot_full   <= ~|position_free;
        end
    end

    assign entry_blk = ~entry_sync[1];
    assign exit_blk  = ~exit_sync[1];
    assign own_blk   = grant_exit ? exit_blk : entry_blk;
    assign req_entry = entry_blk & ~lot_full;
    assign req_exit  = exit_blk;
    assign state_dbg = state;

    always_ff @(posedge clock_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            travel_cnt  <= '0;
            hold_cnt    <= '0;
            grant_entry <= 1'b0;
            grant_exit  <= 1'b0;
            gate_open   <= 1'b0;
            last_served <= LANE_EXIT;
        end else begin
            state       <= state_next;
            travel_cnt  <= travel_next;
            hold_cnt    <= hold_next;
            grant_entry <= grant_entry_next;
            grant_exit  <= grant_exit_next;
            gate_open   <= gate_open_next;
            last_served <= last_next;
        end
    end

    always_comb begin
        state_next       = state;
        travel_next      = travel_cnt;
        hold_next        = hold_cnt;
        grant_entry_next = grant_entry;
        grant_exit_next  = grant_exit;
        last_next        = last_served;
        case (state)
            ST_IDLE: begin
                travel_next = '0;
                hold_next   = '0;
                // On a tie the lane not served last time wins.
                if (req_entry && (!req_exit || last_served == LANE_EXIT)) begin
                    grant_entry_next = 1'b1;
                    state_next       = ST_OPENING;
                end else if (req_exit) begin
                    grant_exit_next = 1'b1;
                    state_next      = ST_OPENING;
                end
            end
            ST_OPENING: begin
                if (travel_cnt == TRAVEL_W'(TRAVEL_CYCLES - 1)) begin
                    travel_next = '0;
                    hold_next   = '0;
                    state_next  = ST_OPEN_HOLD;
                end else begin
                    travel_next = travel_cnt + TRAVEL_W'(1);
                end
            end
            ST_OPEN_HOLD: begin
                if (own_blk) begin
                    hold_next = '0;
                end else if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                    hold_next   = '0;
                    travel_next = '0;
                    state_next  = ST_CLOSING;
                end else begin
                    hold_next = hold_cnt + HOLD_W'(1);
                end
            end
            ST_CLOSING: begin
                // Any car under the arm reverses it, even the other lane's.
                if (entry_blk || exit_blk) begin
                    travel_next = '0;
                    state_next  = ST_OPENING;
                end else if (travel_cnt == TRAVEL_W'(TRAVEL_CYCLES - 1)) begin
                    travel_next      = '0;
                    state_next       = ST_IDLE;
                    grant_entry_next = 1'b0;
                    grant_exit_next  = 1'b0;
                    last_next        = grant_exit ? LANE_EXIT : LANE_ENTRY;
                end else begin
                    travel_next = travel_cnt + TRAVEL_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
        gate_open_next = (state_next == ST_OPEN_HOLD);
    end

`ifdef GATE_WATCHDOG_EN
    localparam int unsigned WDOG_W = cnt_w(WDOG_CYCLES);
    logic [WDOG_W-1:0] wdog_cnt;

    // Flags a beam blocked too long while open; gate behaviour is unaffected.
    always_ff @(posedge clock_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt   <= '0;
            gate_fault <= 1'b0;
        end else if (state == ST_OPEN_HOLD && own_blk) begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
            if (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) begin
                gate_fault <= 1'b1;
            end
        end else begin
            wdog_cnt <= '0;
        end
    end
`else
    assign gate_fault = 1'b0;
`endif

    servo_pwm_gen #(
        .PERIOD_CYCLES(PERIOD_CYCLES),
        .OPEN_PULSE   (OPEN_PULSE),
        .CLOSE_PULSE  (CLOSE_PULSE)
    ) u_pwm (
        .clk        (clock_50MHz),
        .rst_n      (reset_n),
        .target_open(state == ST_OPENING || state == ST_OPEN_HOLD),
        .pwm        (servo_pwm)
    );

endmodule
